// File: rtl/alu_pkg.sv
// Op codes and FSM state encoding shared by the multi-cycle ALU and the decoder
// that drives its alu_operation input.
package alu_pkg;

    localparam int unsigned DataWidth = 32;

    localparam logic [3:0] OpNop  = 4'd0;
    localparam logic [3:0] OpXor  = 4'd1;
    localparam logic [3:0] OpOr   = 4'd2;
    localparam logic [3:0] OpAnd  = 4'd3;
    localparam logic [3:0] OpNor  = 4'd4;
    localparam logic [3:0] OpSll  = 4'd5;
    localparam logic [3:0] OpSrl  = 4'd6;
    localparam logic [3:0] OpSlt  = 4'd7;
    localparam logic [3:0] OpAdd  = 4'd8;
    localparam logic [3:0] OpAddu = 4'd9;
    localparam logic [3:0] OpSub  = 4'd10;
    localparam logic [3:0] OpSubu = 4'd11;
    localparam logic [3:0] OpMult = 4'd12;
    localparam logic [3:0] OpDiv  = 4'd13;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } alu_state_e;

    function automatic logic [DataWidth-1:0] abs32(input logic [DataWidth-1:0] v);
        return v[DataWidth-1] ? -v : v;
    endfunction

    function automatic logic is_muldiv(input logic [3:0] op);
        return (op == OpMult) || (op == OpDiv);
    endfunction

endpackage

// File: rtl/seq_muldiv.sv
// Iterative 32-step signed multiply (shift-add) and divide (restoring) on operand
// magnitudes; the sign fix is folded into the final step that writes hi/lo.
module seq_muldiv
    import alu_pkg::*;
(
    input  logic                 clk_i,
    input  logic                 reset_i,
    input  logic                 load_i,
    input  logic                 is_div_i,
    input  logic                 step_i,
    input  logic [DataWidth-1:0] a_i,
    input  logic [DataWidth-1:0] b_i,
    output logic                 last_o,
    output logic [DataWidth-1:0] hi_o,
    output logic [DataWidth-1:0] lo_o
);

    localparam int unsigned W = DataWidth;

    logic [W-1:0]   mag_a_q, mag_b_q;
    logic [2*W-1:0] acc_q, acc_d;
    logic [4:0]     cnt_q;
    logic           is_div_q, neg_res_q, neg_rem_q, div_zero_q;
    logic [W-1:0]   hi_q, lo_q;

    logic [W:0]     mul_sum, trial;
    logic [2*W-1:0] mul_next, div_next, prod;
    logic [W-1:0]   quo, rem, fix_hi, fix_lo;

    always_comb begin
        // Multiply: accumulate into the upper half, shift the multiplier out the bottom.
        mul_sum  = {1'b0, acc_q[2*W-1:W]} + (acc_q[0] ? {1'b0, mag_a_q} : '0);
        mul_next = {mul_sum, acc_q[W-1:1]};
        // Divide: shift left, trial-subtract the divisor, restore on borrow.
        trial    = {1'b0, acc_q[2*W-2:W-1]} - {1'b0, mag_b_q};
        div_next = trial[W] ? {acc_q[2*W-2:0], 1'b0}
                            : {trial[W-1:0], acc_q[W-2:0], 1'b1};
        acc_d    = is_div_q ? div_next : mul_next;

        prod = neg_res_q ? -acc_d : acc_d;
        quo  = acc_d[W-1:0];
        rem  = acc_d[2*W-1:W];
        if (is_div_q) begin
            // Divide-by-zero: remainder magnitude is |a|, so the sign fix restores a.
            fix_lo = div_zero_q ? '1 : (neg_res_q ? -quo : quo);
            fix_hi = neg_rem_q ? -rem : rem;
        end else begin
            fix_lo = prod[W-1:0];
            fix_hi = prod[2*W-1:W];
        end
    end

    assign last_o = (cnt_q == 5'd0);
    assign hi_o   = hi_q;
    assign lo_o   = lo_q;

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            mag_a_q    <= '0;
            mag_b_q    <= '0;
            acc_q      <= '0;
            cnt_q      <= 5'd0;
            is_div_q   <= 1'b0;
            neg_res_q  <= 1'b0;
            neg_rem_q  <= 1'b0;
            div_zero_q <= 1'b0;
            hi_q       <= '0;
            lo_q       <= '0;
        end else if (load_i) begin
            mag_a_q    <= abs32(a_i);
            mag_b_q    <= abs32(b_i);
            acc_q      <= {{W{1'b0}}, (is_div_i ? abs32(a_i) : abs32(b_i))};
            cnt_q      <= 5'd31;
            is_div_q   <= is_div_i;
            neg_res_q  <= a_i[W-1] ^ b_i[W-1];
            neg_rem_q  <= a_i[W-1];
            div_zero_q <= (b_i == '0);
        end else if (step_i) begin
            acc_q <= acc_d;
            if (last_o) begin
                hi_q <= fix_hi;
                lo_q <= fix_lo;
            end else begin
                cnt_q <= cnt_q - 5'd1;
            end
        end
    end

endmodule

// File: rtl/multi_cycle_alu.sv
// MIPS-style ALU: single-cycle ops complete in one cycle, MULT/DIV run a
// 32-iteration sequential datapath; a three-state FSM sequences both.
module multi_cycle_alu
    import alu_pkg::*;
#(
    parameter int unsigned WIDTH = DataWidth
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [3:0]       alu_operation,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] result,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic             zero,
    output logic             overflow,
    output logic             busy,
    output logic             done
);

    alu_state_e       state_q, state_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic             zero_q, zero_d;
    logic             overflow_q, overflow_d;

    logic [WIDTH-1:0] sum, diff, alu_res;
    logic             alu_ovf, md_load, md_step, md_last;

    always_comb begin
        sum     = a + b;
        diff    = a - b;
        alu_res = '0;
        alu_ovf = 1'b0;
        case (alu_operation)
            OpXor:  alu_res = a ^ b;
            OpOr:   alu_res = a | b;
            OpAnd:  alu_res = a & b;
            OpNor:  alu_res = ~(a | b);
            OpSll:  alu_res = a << b[4:0];
            OpSrl:  alu_res = a >> b[4:0];
            OpSlt:  alu_res = {{(WIDTH-1){1'b0}}, ($signed(a) < $signed(b))};
            OpAdd: begin
                alu_res = sum;
                alu_ovf = (a[WIDTH-1] == b[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);
            end
            OpAddu: alu_res = sum;
            OpSub: begin
                alu_res = diff;
                alu_ovf = (a[WIDTH-1] != b[WIDTH-1]) && (diff[WIDTH-1] != a[WIDTH-1]);
            end
            OpSubu: alu_res = diff;
            default: alu_res = '0;
        endcase
    end

    always_comb begin
        state_d    = state_q;
        result_d   = result_q;
        zero_d     = zero_q;
        overflow_d = overflow_q;
        md_load    = 1'b0;
        md_step    = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    if (is_muldiv(alu_operation)) begin
                        md_load = 1'b1;
                        state_d = RUN;
                    end else begin
                        result_d   = alu_res;
                        zero_d     = (alu_res == '0);
                        overflow_d = alu_ovf;
                        state_d    = DONE;
                    end
                end
            end
            RUN: begin
                md_step = 1'b1;
                if (md_last) state_d = DONE;
            end
            DONE: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            result_q   <= '0;
            zero_q     <= 1'b1;
            overflow_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            result_q   <= result_d;
            zero_q     <= zero_d;
            overflow_q <= overflow_d;
        end
    end

    seq_muldiv u_muldiv (
        .clk_i    (clk),
        .reset_i  (reset),
        .load_i   (md_load),
        .is_div_i (alu_operation == OpDiv),
        .step_i   (md_step),
        .a_i      (a),
        .b_i      (b),
        .last_o   (md_last),
        .hi_o     (hi),
        .lo_o     (lo)
    );

    assign result   = result_q;
    assign zero     = zero_q;
    assign overflow = overflow_q;
    assign busy     = (state_q != IDLE);
    assign done     = (state_q == DONE);

endmodule

// File: tb/tb_multi_cycle_alu.sv
// Directed self-checking bench for multi_cycle_alu with hand-computed expectations.
module tb_multi_cycle_alu;
    import alu_pkg::*;

    logic        clk, reset, start;
    logic [3:0]  alu_operation;
    logic [31:0] a, b;
    logic [31:0] result, hi, lo;
    logic        zero, overflow, busy, done;

    int n_cmp  = 0;
    int n_fail = 0;

    logic [31:0] exp_res, exp_hi, exp_lo;
    logic        exp_zero, exp_ovf;

    multi_cycle_alu #(.WIDTH(32)) dut (
        .clk           (clk),
        .reset         (reset),
        .start         (start),
        .alu_operation (alu_operation),
        .a             (a),
        .b             (b),
        .result        (result),
        .hi            (hi),
        .lo            (lo),
        .zero          (zero),
        .overflow      (overflow),
        .busy          (busy),
        .done          (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h required %h", tag, obs, exp);
        end
    endtask

    task automatic check_bit(input string tag, input logic obs, input logic exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %b required %b", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Returns 1 ns after the edge that samples start (cycle 1).
    task automatic issue(input logic [3:0] op, input logic [31:0] aa, input logic [31:0] bb);
        @(negedge clk);
        start         = 1'b1;
        alu_operation = op;
        a             = aa;
        b             = bb;
        tick();
        start = 1'b0;
    endtask

    task automatic sc(input string tag, input logic [3:0] op, input logic [31:0] aa,
                      input logic [31:0] bb, input logic [31:0] er, input logic ez,
                      input logic eo);
        issue(op, aa, bb);
        exp_res  = er;
        exp_zero = ez;
        exp_ovf  = eo;
        check({tag, ".result"}, result, exp_res);
        check_bit({tag, ".zero"}, zero, exp_zero);
        check_bit({tag, ".overflow"}, overflow, exp_ovf);
        check_bit({tag, ".done"}, done, 1'b1);
        check_bit({tag, ".busy"}, busy, 1'b1);
        check({tag, ".hi_kept"}, hi, exp_hi);
        check({tag, ".lo_kept"}, lo, exp_lo);
        tick();
        check_bit({tag, ".done_drop"}, done, 1'b0);
        check_bit({tag, ".idle"}, busy, 1'b0);
    endtask

    task automatic md(input string tag, input logic [3:0] op, input logic [31:0] aa,
                      input logic [31:0] bb, input logic [31:0] eh, input logic [31:0] el);
        issue(op, aa, bb);
        for (int k = 1; k <= 33; k++) begin
            check_bit({tag, $sformatf(".busy@%0d", k)}, busy, 1'b1);
            check_bit({tag, $sformatf(".done@%0d", k)}, done, (k == 33));
            if (k == 32) check({tag, ".hi_early"}, hi, exp_hi);
            if (k < 33) tick();
        end
        exp_hi = eh;
        exp_lo = el;
        check({tag, ".hi"}, hi, exp_hi);
        check({tag, ".lo"}, lo, exp_lo);
        check({tag, ".result_kept"}, result, exp_res);
        check_bit({tag, ".zero_kept"}, zero, exp_zero);
        check_bit({tag, ".ovf_kept"}, overflow, exp_ovf);
        tick();
        check_bit({tag, ".done_drop"}, done, 1'b0);
        check_bit({tag, ".idle"}, busy, 1'b0);
    endtask

    initial begin
        reset         = 1'b1;
        start         = 1'b0;
        alu_operation = 4'd0;
        a             = '0;
        b             = '0;
        repeat (2) tick();
        check("rst.result", result, 32'h0);
        check("rst.hi", hi, 32'h0);
        check("rst.lo", lo, 32'h0);
        check_bit("rst.zero", zero, 1'b1);
        check_bit("rst.overflow", overflow, 1'b0);
        check_bit("rst.busy", busy, 1'b0);
        check_bit("rst.done", done, 1'b0);
        reset    = 1'b0;
        exp_hi   = 32'h0;
        exp_lo   = 32'h0;
        exp_res  = 32'h0;
        exp_zero = 1'b1;
        exp_ovf  = 1'b0;

        sc("add_ovf",  OpAdd,  32'h7FFFFFFF, 32'h1, 32'h80000000, 1'b0, 1'b1);
        sc("addu",     OpAddu, 32'h7FFFFFFF, 32'h1, 32'h80000000, 1'b0, 1'b0);
        sc("sub_ovf",  OpSub,  32'h80000000, 32'h1, 32'h7FFFFFFF, 1'b0, 1'b1);
        sc("add_zero", OpAdd,  32'hFFFFFFFF, 32'h1, 32'h00000000, 1'b1, 1'b0);
        sc("xor",      OpXor,  32'hF0F0F0F0, 32'hFF00FF00, 32'h0FF00FF0, 1'b0, 1'b0);
        sc("op15",     4'd15,  32'h12345678, 32'h9ABCDEF0, 32'h00000000, 1'b1, 1'b0);
        sc("or",       OpOr,   32'hF0F0F0F0, 32'h0F0F0000, 32'hFFFFF0F0, 1'b0, 1'b0);
        sc("and",      OpAnd,  32'hF0F0F0F0, 32'h0FF00FF0, 32'h00F000F0, 1'b0, 1'b0);
        sc("nor",      OpNor,  32'h0, 32'h0, 32'hFFFFFFFF, 1'b0, 1'b0);
        sc("sll",      OpSll,  32'h1, 32'h24, 32'h00000010, 1'b0, 1'b0);
        sc("srl",      OpSrl,  32'h80000000, 32'd31, 32'h00000001, 1'b0, 1'b0);
        sc("slt_t",    OpSlt,  32'hFFFFFFFF, 32'h1, 32'h00000001, 1'b0, 1'b0);
        sc("slt_f",    OpSlt,  32'h1, 32'hFFFFFFFF, 32'h00000000, 1'b1, 1'b0);
        sc("subu",     OpSubu, 32'h0, 32'h1, 32'hFFFFFFFF, 1'b0, 1'b0);
        sc("nop",      OpNop,  32'h5, 32'h6, 32'h00000000, 1'b1, 1'b0);
        sc("add_pos",  OpAdd,  32'h2, 32'h3, 32'h00000005, 1'b0, 1'b0);

        md("mult_neg", OpMult, 32'hFFFFFFFD, 32'd5, 32'hFFFFFFFF, 32'hFFFFFFF1);
        md("div_neg",  OpDiv,  32'hFFFFFFF9, 32'd2, 32'hFFFFFFFF, 32'hFFFFFFFD);
        md("div_zero", OpDiv,  32'd9, 32'd0, 32'h00000009, 32'hFFFFFFFF);
        md("div_min",  OpDiv,  32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000);
        sc("add_keep", OpAdd,  32'h2, 32'h3, 32'h00000005, 1'b0, 1'b0);
        md("mult_max", OpMult, 32'h7FFFFFFF, 32'h7FFFFFFF, 32'h3FFFFFFF, 32'h00000001);

        // MULT in flight: a SUB issued at cycle 5 must be ignored, reset at cycle 10 aborts.
        issue(OpMult, 32'hFFFFFFFD, 32'd5);
        repeat (4) tick();
        @(negedge clk);
        start         = 1'b1;
        alu_operation = OpSub;
        a             = 32'd10;
        b             = 32'd3;
        tick();
        start = 1'b0;
        check_bit("abort.busy_c6", busy, 1'b1);
        check_bit("abort.done_c6", done, 1'b0);
        check("abort.result_c6", result, exp_res);
        repeat (4) tick();
        check("abort.result_c10", result, exp_res);
        @(negedge clk);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check_bit("abort.busy_c11", busy, 1'b0);
        check_bit("abort.done_c11", done, 1'b0);
        check("abort.hi_c11", hi, 32'h0);
        check("abort.lo_c11", lo, 32'h0);
        check("abort.result_c11", result, 32'h0);
        check_bit("abort.zero_c11", zero, 1'b1);
        check_bit("abort.ovf_c11", overflow, 1'b0);
        for (int k = 12; k < 52; k++) begin
            tick();
            check_bit($sformatf("abort.no_done@%0d", k), done, 1'b0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/multi_cycle_alu.md
MULTI_CYCLE_ALU -- requirements
Module: multi_cycle_alu

Interface
REQ-001 Parameter: WIDTH, 32, operand/result width; only 32 is supported.
REQ-002 Ports, clock and reset first:
- clk  in  1  single clock; all state updates on rising edge.
- reset  in  1  synchronous, active-high.
- start  in  1  issue request; sampled only in IDLE.
- alu_operation  in  4  op code: NOP=0, XOR=1, OR=2, AND=3, NOR=4, SLL=5, SRL=6, SLT=7, ADD=8, ADDU=9, SUB=10, SUBU=11, MULT=12, DIV=13.
- a  in  32  operand A (rs).
- b  in  32  operand B (rt/immediate).
- result  out  32  registered result of last completed single-cycle op.
- hi  out  32  MULT upper product / DIV remainder.
- lo  out  32  MULT lower product / DIV quotient.
- zero  out  1  result == 0, registered with result.
- overflow  out  1  signed overflow of last ADD/SUB.
- busy  out  1  state != IDLE.
- done  out  1  one-cycle completion pulse.

Function
REQ-003 The FSM SHALL have states IDLE, RUN and DONE.
REQ-004 In IDLE with start=1, the block SHALL latch alu_operation, a and b; start in any other state SHALL be ignored.
REQ-005 Single-cycle ops (codes 0-11, plus 14/15 treated as NOP) SHALL update result/zero/overflow at the start edge, go to DONE, and assert done the next cycle (latency 1).
REQ-006 Logic ops are bitwise; SLL = a << b[4:0]; SRL = a >> b[4:0] (logical); SLT = 1 if $signed(a) < $signed(b), else 0.
REQ-007 ADD/SUB: result SHALL be the 32-bit two's-complement sum/difference; overflow SHALL be signed overflow. ADDU/SUBU: result wraps and overflow=0. All other ops: overflow=0.
REQ-008 NOP SHALL set result=0 and zero=1.
REQ-009 MULT/DIV SHALL go to RUN for exactly 32 iterations using a 5-bit down-counter from 31.
- Iterations SHALL operate on operand magnitudes.
- On the last iteration the sign fix SHALL apply and hi/lo SHALL update.
- The FSM SHALL then enter DONE, with done asserted 33 cycles after the start edge.
REQ-010 MULT SHALL be signed shift-add: {hi,lo} = $signed(a) * $signed(b), 64 bits.
REQ-011 DIV SHALL be signed restoring division:
- lo = quotient, truncated toward zero.
- hi = remainder, carrying the sign of a.
REQ-012 DIV with b=0 SHALL take the full 33 cycles and yield lo=32'hFFFFFFFF, hi=a.
REQ-013 DIV of 32'h80000000 by -1 SHALL yield lo=32'h80000000, hi=0.
REQ-014 MULT/DIV SHALL leave result, zero and overflow unchanged; single-cycle ops SHALL leave hi and lo unchanged.
REQ-015 DONE SHALL last exactly one cycle and then return to IDLE, so back-to-back single-cycle issue is possible every 2 cycles.
REQ-016 done SHALL equal (state == DONE); busy SHALL be high in RUN and DONE.

Reset
REQ-017 reset=1 SHALL, at the next edge and from any state (including mid-RUN), force:
- state to IDLE;
- result, hi, lo and the iteration counter to 0;
- zero=1, overflow=0, busy=0, done=0.
REQ-018 reset SHALL take priority over start on the same edge.

Structure
REQ-019 Package alu_pkg SHALL hold the 4-bit op code localparams and the state enum (IDLE, RUN, DONE), shared with the decoder that produces alu_operation.
REQ-020 The iterative multiply/divide datapath SHALL be the sub-module seq_muldiv, containing:
- magnitude registers;
- 64-bit accumulator/remainder;
- counter;
- sign fix logic.
The top module SHALL hold the FSM and the single-cycle datapath.

Verification
REQ-021 ADD a=32'h7FFFFFFF, b=1 -> result=32'h80000000, overflow=1, done 1 cycle after start. ADDU with the same operands -> overflow=0.
REQ-022 MULT a=-3, b=5 -> hi=32'hFFFFFFFF, lo=32'hFFFFFFF1, done exactly 33 cycles after start, busy high for cycles 1-33.
REQ-023 DIV a=-7, b=2 -> lo=32'hFFFFFFFD, hi=32'hFFFFFFFF.
REQ-024 DIV a=9, b=0 -> lo=32'hFFFFFFFF, hi=9, done at cycle 33.
REQ-025 MULT started, start pulsed with SUB at cycle 5 -> SUB ignored, result unchanged. Then reset at cycle 10 -> busy=0, hi=lo=0 at cycle 11, no done pulse.
REQ-026 SLT a=32'hFFFFFFFF, b=1 -> result=1, zero=0. SRL a=32'h80000000, b=31 -> result=1.
